dual_port_block_ram: RTL and testbench
======================================

Name: dual_port_block_ram

Overview:
- Simple dual-port synchronous block RAM: one read port, one write port, single clock.
- The write port also returns the entry it overwrites (evict output).
- Storage primitive for cache tag/data arrays; one entry per set, NUM_SET sets.
- Infers FPGA block RAM: the storage array is not reset; only output registers are.

Parameters:
- SINGLE_ENTRY_SIZE_IN_BITS, 64, width of one entry.
- NUM_SET, 64, number of entries (sets).
- SET_PTR_WIDTH_IN_BITS, 6, address width; must equal clog2(NUM_SET).

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- reset_in  input  1  asynchronous, active-low reset; clears output registers only.
- read_en_in  input  1  read enable.
- read_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  read address.
- read_entry_out  output  SINGLE_ENTRY_SIZE_IN_BITS  registered read data.
- write_en_in  input  1  write enable.
- write_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write address.
- write_entry_in  input  SINGLE_ENTRY_SIZE_IN_BITS  write data.
- evict_entry_out  output  SINGLE_ENTRY_SIZE_IN_BITS  registered previous content of the written entry.

Behaviour:
- Reset:
  - reset_in=0 asynchronously forces read_entry_out=0 and evict_entry_out=0.
  - Array contents are untouched and power up as X in simulation.
  - While reset is low, reads and writes are ignored.
- Read:
  - On posedge with read_en_in=1: read_entry_out <= mem[read_set_addr_in].
  - Latency is 1 cycle.
  - With read_en_in=0, read_entry_out holds its last value.
- Write:
  - On posedge with write_en_in=1: mem[write_set_addr_in] <= write_entry_in.
  - In the same edge: evict_entry_out <= old mem[write_set_addr_in] (read-before-write).
  - With write_en_in=0, nothing is written (write_entry_in ignored) and evict_entry_out holds.
- Same-address collision (read and write same set, same edge): read returns OLD data (read-first). New data is visible on the next enabled read edge.
- Repeated writes: consecutive enabled writes to the same set return the previously written value on evict_entry_out each cycle.
- Addresses are used modulo 2^SET_PTR_WIDTH_IN_BITS; wrap-around is legal (address 64 in 6 bits = set 0).
- No X-propagation guard: X data written is stored as X.
- Read and write ports are fully independent; both may be active every cycle to any addresses.

Test Plan:
- Write then read:
  - Write 0xFFFFFFFF_00000000 to set 0 (64 truncated) for one cycle, then keep read_en_in=1 on set 0.
  - Required: read_entry_out = 0xFFFFFFFF_00000000 one cycle later, not X.
- Simultaneous read/write:
  - Hold read_en_in=1 on set 63 with no write enabled (write_entry_in=X); then drive 0xFFFFFFFF_FFFFFFFF and raise write_en_in.
  - Required: read_entry_out = 0xFFFFFFFF_FFFFFFFF from 2 cycles after write enable (first cycle returns old/X).
- Evict:
  - Write 0x00000000_FFFFFFFF to set 62, idle one cycle, then write 0xFFFFFFFF_00000000 to set 62 for one cycle.
  - Required: evict_entry_out = 0x00000000_FFFFFFFF, held for 5+ cycles afterwards.
- Write enable gating:
  - Write 0x00000000_FFFFFFFF to set 61 for 10 cycles, drop write_en_in, then change write_entry_in to 0xFFFFFFFF_00000000.
  - Required: read of set 61 returns 0x00000000_FFFFFFFF.
- Reset:
  - Assert reset_in=0 mid-operation, asynchronous to the clock.
  - Required: both outputs = 0 immediately.
  - After release, a read of a previously written set returns the stored data (array not cleared).
- Independent ports:
  - Write set 5 while reading set 9 on the same edges.
  - Required: read returns set-9 data; evict returns prior set-5 data.

Source files
------------

// File: rtl/dual_port_block_ram.sv
// Simple dual-port block RAM: one read port, one write port, single clock.
// The write port also returns the entry it overwrites (read-before-write).
module dual_port_block_ram #(
   parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
   parameter int NUM_SET                   = 64,
   parameter int SET_PTR_WIDTH_IN_BITS     = 6
) (
   input  logic                                 clk_in,
   input  logic                                 reset_in,
   input  logic                                 read_en_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     read_set_addr_in,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out,
   input  logic                                 write_en_in,
   input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     write_set_addr_in,
   input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
   output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] evict_entry_out
);

   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem_q [NUM_SET];
   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_q;
   logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] evict_entry_q;

   // Array has no reset so it maps onto block RAM; writes are still held off during reset.
   always_ff @(posedge clk_in) begin
      if (reset_in && write_en_in)
         mem_q[write_set_addr_in] <= write_entry_in;
   end

   // Both ports sample the pre-edge array contents, giving read-first collision behaviour.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         read_entry_q  <= '0;
         evict_entry_q <= '0;
      end else begin
         if (read_en_in)
            read_entry_q <= mem_q[read_set_addr_in];
         if (write_en_in)
            evict_entry_q <= mem_q[write_set_addr_in];
      end
   end

   assign read_entry_out  = read_entry_q;
   assign evict_entry_out = evict_entry_q;

endmodule

// File: tb/tb_dual_port_block_ram.sv
// Directed bench for dual_port_block_ram with hand-computed expected values.
module tb_dual_port_block_ram;

   localparam int W  = 64;
   localparam int AW = 6;

   localparam logic [W-1:0] HI_ONES = 64'hFFFFFFFF_00000000;
   localparam logic [W-1:0] LO_ONES = 64'h00000000_FFFFFFFF;
   localparam logic [W-1:0] ALL1    = 64'hFFFFFFFF_FFFFFFFF;
   localparam logic [W-1:0] D9      = 64'h12345678_9ABCDEF0;
   localparam logic [W-1:0] D5A     = 64'hAAAAAAAA_AAAAAAAA;
   localparam logic [W-1:0] D5B     = 64'h55555555_55555555;
   localparam logic [W-1:0] D62C    = 64'hC0FFEE00_0BADF00D;

   logic          clk_in;
   logic          reset_in;
   logic          read_en_in;
   logic [AW-1:0] read_set_addr_in;
   logic [W-1:0]  read_entry_out;
   logic          write_en_in;
   logic [AW-1:0] write_set_addr_in;
   logic [W-1:0]  write_entry_in;
   logic [W-1:0]  evict_entry_out;

   int n_chk = 0;
   int n_err = 0;

   dual_port_block_ram #(
      .SINGLE_ENTRY_SIZE_IN_BITS(W),
      .NUM_SET(64),
      .SET_PTR_WIDTH_IN_BITS(AW)
   ) dut (
      .clk_in            (clk_in),
      .reset_in          (reset_in),
      .read_en_in        (read_en_in),
      .read_set_addr_in  (read_set_addr_in),
      .read_entry_out    (read_entry_out),
      .write_en_in       (write_en_in),
      .write_set_addr_in (write_set_addr_in),
      .write_entry_in    (write_entry_in),
      .evict_entry_out   (evict_entry_out)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, then return 1 time unit after the rising edge.
   task automatic cyc(input logic re, input logic [AW-1:0] ra,
                      input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd);
      read_en_in        = re;
      read_set_addr_in  = ra;
      write_en_in       = we;
      write_set_addr_in = wa;
      write_entry_in    = wd;
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      logic [AW:0] addr64;
      addr64 = 7'd64;

      reset_in          = 1'b0;
      read_en_in        = 1'b0;
      read_set_addr_in  = '0;
      write_en_in       = 1'b0;
      write_set_addr_in = '0;
      write_entry_in    = '0;
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_read", read_entry_out, '0);
      chk("rst_evict", evict_entry_out, '0);
      #2 reset_in = 1'b1;

      // Write then read; address 64 wraps to set 0
      cyc(1'b0, '0, 1'b1, addr64[AW-1:0], HI_ONES);
      cyc(1'b1, 6'd0, 1'b0, '0, '0);
      chk("wr_rd_set0", read_entry_out, HI_ONES);
      cyc(1'b1, 6'd0, 1'b0, '0, '0);
      chk("wr_rd_set0_hold_en", read_entry_out, HI_ONES);

      // Simultaneous read/write on set 63
      cyc(1'b1, 6'd63, 1'b0, '0, 'x);
      cyc(1'b1, 6'd63, 1'b1, 6'd63, ALL1);
      cyc(1'b1, 6'd63, 1'b0, 6'd63, ALL1);
      chk("rw_set63", read_entry_out, ALL1);
      // Read disabled: output holds even though set 63 changes
      cyc(1'b0, 6'd0, 1'b1, 6'd63, D5B);
      chk("read_hold", read_entry_out, ALL1);
      chk("evict_set63", evict_entry_out, ALL1);

      // Evict on set 62
      cyc(1'b0, '0, 1'b1, 6'd62, LO_ONES);
      cyc(1'b0, '0, 1'b0, '0, '0);
      cyc(1'b0, '0, 1'b1, 6'd62, HI_ONES);
      chk("evict_set62", evict_entry_out, LO_ONES);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, '0, 1'b0, 6'd62, ALL1);
         chk($sformatf("evict_hold_%0d", i), evict_entry_out, LO_ONES);
      end
      // Same-address collision: read returns old data, new visible next edge
      cyc(1'b1, 6'd62, 1'b1, 6'd62, D62C);
      chk("coll_read_old", read_entry_out, HI_ONES);
      chk("coll_evict", evict_entry_out, HI_ONES);
      // Back-to-back writes to same set evict the previous write each cycle
      cyc(1'b1, 6'd62, 1'b1, 6'd62, LO_ONES);
      chk("coll_read_new", read_entry_out, D62C);
      chk("b2b_evict0", evict_entry_out, D62C);
      cyc(1'b0, '0, 1'b1, 6'd62, ALL1);
      chk("b2b_evict1", evict_entry_out, LO_ONES);

      // Write enable gating on set 61
      for (int i = 0; i < 10; i++)
         cyc(1'b0, '0, 1'b1, 6'd61, LO_ONES);
      chk("wr61_evict", evict_entry_out, LO_ONES);
      cyc(1'b0, '0, 1'b0, 6'd61, HI_ONES);
      cyc(1'b0, '0, 1'b0, 6'd61, HI_ONES);
      chk("we_gate_evict", evict_entry_out, LO_ONES);
      cyc(1'b1, 6'd61, 1'b0, 6'd61, HI_ONES);
      chk("we_gate_read", read_entry_out, LO_ONES);

      // Independent ports
      cyc(1'b0, '0, 1'b1, 6'd9, D9);
      cyc(1'b0, '0, 1'b1, 6'd5, D5A);
      cyc(1'b1, 6'd9, 1'b1, 6'd5, D5B);
      chk("indep_read9", read_entry_out, D9);
      chk("indep_evict5", evict_entry_out, D5A);

      // Asynchronous reset mid-operation
      read_en_in = 1'b1;
      read_set_addr_in = 6'd5;
      #3 reset_in = 1'b0;
      #1;
      chk("async_rst_read", read_entry_out, '0);
      chk("async_rst_evict", evict_entry_out, '0);
      // Enabled traffic during reset is ignored
      cyc(1'b1, 6'd9, 1'b1, 6'd9, ALL1);
      cyc(1'b1, 6'd9, 1'b1, 6'd9, ALL1);
      chk("in_rst_read", read_entry_out, '0);
      chk("in_rst_evict", evict_entry_out, '0);
      #2 reset_in = 1'b1;
      cyc(1'b1, 6'd9, 1'b0, '0, '0);
      chk("post_rst_read9", read_entry_out, D9);
      chk("post_rst_evict", evict_entry_out, '0);
      cyc(1'b1, 6'd5, 1'b1, 6'd61, HI_ONES);
      chk("post_rst_read5", read_entry_out, D5B);
      chk("post_rst_evict61", evict_entry_out, LO_ONES);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000");
      $fatal(1);
   end

endmodule
